// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer slice.
package store_write_buffer_pkg;

  localparam int WB_DEPTH_DEFAULT = 4;

  // One buffered retired store: word address, word-aligned data, byte lanes.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wb_entry_t;

  // Widen a 4-bit byte mask into a 32-bit bit mask.
  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/store_wb_fwd.sv
// Load forwarding: per byte lane, the youngest valid entry with a matching
// word address and a set mask bit supplies the byte.
module store_wb_fwd
  import store_write_buffer_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  wb_entry_t [WB_DEPTH-1:0]         entries,
  input  logic      [WB_DEPTH-1:0]         valid,
  input  logic      [$clog2(WB_DEPTH)-1:0] head,
  input  logic      [29:0]                 ld_word,
  output logic      [31:0]                 fwd_data,
  output logic      [3:0]                  fwd_mask
);

  localparam int PTR_W = $clog2(WB_DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk entries oldest to youngest so younger matches overwrite older ones.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    idx      = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (entries[idx].word_addr == ld_word)) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].mask[b]) begin
            fwd_data[8*b +: 8] = entries[idx].data[8*b +: 8];
            fwd_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: circular FIFO of retired stores draining to the dcache,
// with coalescing into the youngest non-head entry and load forwarding.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sq_valid,
  input  logic [31:0]                 sq_addr,
  input  logic [31:0]                 sq_data,
  input  logic [3:0]                  sq_byte_mask,
  output logic                        sq_accept,
  output logic                        dc_req_valid,
  output logic [31:0]                 dc_req_addr,
  output logic [31:0]                 dc_req_data,
  output logic [3:0]                  dc_req_byte_mask,
  input  logic                        dc_req_accept,
  input  logic [31:0]                 ld_addr,
  output logic [31:0]                 fwd_data,
  output logic [3:0]                  fwd_mask,
  output logic [$clog2(WB_DEPTH):0]   count,
  output logic                        empty
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [WB_DEPTH-1:0] entries;
  logic      [WB_DEPTH-1:0] valid;
  logic      [PTR_W-1:0]    head;
  logic      [PTR_W-1:0]    tail;
  logic      [PTR_W-1:0]    youngest;
  logic      [CNT_W-1:0]    count_q;
  logic                     coalesce;
  logic                     enq_new;
  logic                     deq;
  logic      [31:0]         sq_bits;
  logic                     unused_low_bits;

  // Byte offsets within a word carry no meaning here.
  assign unused_low_bits = ^{sq_addr[1:0], ld_addr[1:0]};

  assign youngest = tail - PTR_W'(1);
  assign sq_bits  = expand_mask(sq_byte_mask);

  // Merging needs a youngest entry that is not the head, i.e. at least two entries.
  assign coalesce = sq_valid && (count_q >= CNT_W'(2)) &&
                    (entries[youngest].word_addr == sq_addr[31:2]);

  // A full buffer does not accept in the same cycle the head drains.
  assign sq_accept = reset && sq_valid && (coalesce || (count_q < CNT_W'(WB_DEPTH)));
  assign enq_new   = sq_accept && !coalesce;

  assign dc_req_valid     = (count_q != '0);
  assign deq              = dc_req_valid && dc_req_accept;
  assign dc_req_addr      = dc_req_valid ? {entries[head].word_addr, 2'b00} : '0;
  assign dc_req_data      = dc_req_valid ? entries[head].data : '0;
  assign dc_req_byte_mask = dc_req_valid ? entries[head].mask : '0;

  assign count = count_q;
  assign empty = (count_q == '0);

  // Pointer, occupancy and entry storage updates for enqueue, merge and drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries <= '0;
      valid   <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (sq_accept && coalesce) begin
        entries[youngest].data <= (entries[youngest].data & ~sq_bits) | (sq_data & sq_bits);
        entries[youngest].mask <= entries[youngest].mask | sq_byte_mask;
      end else if (enq_new) begin
        entries[tail].word_addr <= sq_addr[31:2];
        entries[tail].data      <= sq_data & sq_bits;
        entries[tail].mask      <= sq_byte_mask;
        valid[tail]             <= 1'b1;
        tail                    <= tail + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(enq_new) - CNT_W'(deq);
    end
  end

  store_wb_fwd #(.WB_DEPTH(WB_DEPTH)) u_fwd (
    .entries  (entries),
    .valid    (valid),
    .head     (head),
    .ld_word  (ld_addr[31:2]),
    .fwd_data (fwd_data),
    .fwd_mask (fwd_mask)
  );

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_store_write_buffer;

  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sq_valid = 1'b0;
  logic [31:0] sq_addr = '0;
  logic [31:0] sq_data = '0;
  logic [3:0]  sq_byte_mask = '0;
  logic        sq_accept;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_data;
  logic [3:0]  dc_req_byte_mask;
  logic        dc_req_accept = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic [CW-1:0] count;
  logic        empty;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t q[$];

  store_write_buffer #(.WB_DEPTH(D)) dut (
    .clock            (clock),
    .reset            (reset),
    .sq_valid         (sq_valid),
    .sq_addr          (sq_addr),
    .sq_data          (sq_data),
    .sq_byte_mask     (sq_byte_mask),
    .sq_accept        (sq_accept),
    .dc_req_valid     (dc_req_valid),
    .dc_req_addr      (dc_req_addr),
    .dc_req_data      (dc_req_data),
    .dc_req_byte_mask (dc_req_byte_mask),
    .dc_req_accept    (dc_req_accept),
    .ld_addr          (ld_addr),
    .fwd_data         (fwd_data),
    .fwd_mask         (fwd_mask),
    .count            (count),
    .empty            (empty)
  );

  always #5 clock = ~clock;

  // Model: merge only into the youngest entry, and only when it is not the head.
  function automatic logic m_coal();
    if (!sq_valid || q.size() < 2) return 1'b0;
    return q[q.size()-1].a == sq_addr[31:2];
  endfunction

  function automatic logic m_acc();
    return sq_valid && (m_coal() || q.size() < D);
  endfunction

  function automatic logic [35:0] m_fwd(input logic [31:0] la);
    logic [31:0] fd;
    logic [3:0]  fm;
    fd = '0;
    fm = '0;
    foreach (q[i])
      if (q[i].a == la[31:2])
        for (int b = 0; b < 4; b++)
          if (q[i].m[b]) begin
            fd[8*b +: 8] = q[i].d[8*b +: 8];
            fm[b] = 1'b1;
          end
    return {fm, fd};
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    logic c, a, dq;
    ent_t e;
    c  = m_coal();
    a  = m_acc();
    dq = dc_req_accept && (q.size() > 0);
    @(posedge clock);
    #1;
    if (dq) void'(q.pop_front());
    if (a) begin
      if (c) begin
        e = q[q.size()-1];
        for (int b = 0; b < 4; b++)
          if (sq_byte_mask[b]) e.d[8*b +: 8] = sq_data[8*b +: 8];
        e.m = e.m | sq_byte_mask;
        q[q.size()-1] = e;
      end else begin
        e.a = sq_addr[31:2];
        e.m = sq_byte_mask;
        e.d = '0;
        for (int b = 0; b < 4; b++)
          if (sq_byte_mask[b]) e.d[8*b +: 8] = sq_data[8*b +: 8];
        q.push_back(e);
      end
    end
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    sq_valid = v;
    sq_addr = a;
    sq_data = d;
    sq_byte_mask = m;
  endtask

  task automatic do_reset();
    set_store(1'b0, '0, '0, '0);
    dc_req_accept = 1'b0;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    q.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    set_store(1'b0, '0, '0, '0);
    ld_addr = 32'h0;
    reset = 1'b0;
    #7;
    checks++;
    if ({dc_req_valid, dc_req_addr, dc_req_data, dc_req_byte_mask} !== 69'h0) begin
      failures++;
      $display("[TB] FAIL reset_dcreq got v=%0b a=%h d=%h m=%h want all 0", dc_req_valid, dc_req_addr, dc_req_data, dc_req_byte_mask);
    end
    checks++;
    if ({sq_accept, fwd_data, fwd_mask} !== 37'h0) begin
      failures++;
      $display("[TB] FAIL reset_outs got acc=%0b fd=%h fm=%h want 0", sq_accept, fwd_data, fwd_mask);
    end
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_count got count=%0d empty=%0b want 0/1", count, empty);
    end
    reset = 1'b1;
    q.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_store();
    do_reset();
    set_store(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    checks++;
    if (sq_accept !== 1'b1 || dc_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_accept got acc=%0b v=%0b want 1/0", sq_accept, dc_req_valid);
    end
    tick();
    set_store(1'b0, '0, '0, '0);
    #1;
    checks++;
    if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h100 || dc_req_data !== 32'hDEADBEEF ||
        dc_req_byte_mask !== 4'hF || count !== CW'(1) || empty !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_head got v=%0b a=%h d=%h m=%h c=%0d want 1/100/deadbeef/f/1",
               dc_req_valid, dc_req_addr, dc_req_data, dc_req_byte_mask, count);
    end
    dc_req_accept = 1'b1;
    tick();
    dc_req_accept = 1'b0;
    #1;
    checks++;
    if (count !== '0 || dc_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_drain got c=%0d v=%0b want 0/0", count, dc_req_valid);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_store(1'b1, 32'h1000 + 32'(16*i), 32'h11110000 + 32'(i), 4'hF);
      #1;
      checks++;
      if (sq_accept !== (i < 4)) begin
        failures++;
        $display("[TB] FAIL full_accept%0d got %0b want %0b", i, sq_accept, (i < 4));
      end
      if (i < 4) tick();
    end
    checks++;
    if (count !== CW'(4) || dc_req_addr !== 32'h1000) begin
      failures++;
      $display("[TB] FAIL full_count got c=%0d a=%h want 4/1000", count, dc_req_addr);
    end
    dc_req_accept = 1'b1;
    #1;
    checks++;
    if (sq_accept !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_nobypass got %0b want 0", sq_accept);
    end
    tick();
    dc_req_accept = 1'b0;
    #1;
    checks++;
    if (sq_accept !== 1'b1 || count !== CW'(3)) begin
      failures++;
      $display("[TB] FAIL full_afterdrain got acc=%0b c=%0d want 1/3", sq_accept, count);
    end
    tick();
    set_store(1'b0, '0, '0, '0);
    #1;
    checks++;
    if (count !== CW'(4) || dc_req_addr !== 32'h1010) begin
      failures++;
      $display("[TB] FAIL full_refill got c=%0d a=%h want 4/1010", count, dc_req_addr);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    set_store(1'b1, 32'h200, 32'h00001122, 4'b0011);
    tick();
    set_store(1'b1, 32'h204, 32'h33440000, 4'b1100);
    tick();
    set_store(1'b1, 32'h204, 32'h00005566, 4'b0011);
    #1;
    checks++;
    if (sq_accept !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coal_accept got %0b want 1", sq_accept);
    end
    tick();
    set_store(1'b0, '0, '0, '0);
    ld_addr = 32'h204;
    #1;
    checks++;
    if (count !== CW'(2) || fwd_data !== 32'h33445566 || fwd_mask !== 4'hF) begin
      failures++;
      $display("[TB] FAIL coal_merge got c=%0d fd=%h fm=%h want 2/33445566/f", count, fwd_data, fwd_mask);
    end
    dc_req_accept = 1'b1;
    tick();
    dc_req_accept = 1'b0;
    #1;
    checks++;
    if (dc_req_addr !== 32'h204 || dc_req_data !== 32'h33445566 || dc_req_byte_mask !== 4'hF) begin
      failures++;
      $display("[TB] FAIL coal_entry got a=%h d=%h m=%h want 204/33445566/f", dc_req_addr, dc_req_data, dc_req_byte_mask);
    end
  endtask

  task automatic test_head_no_coalesce();
    do_reset();
    set_store(1'b1, 32'h300, 32'h01020304, 4'hF);
    tick();
    set_store(1'b1, 32'h300, 32'h0A0B0C0D, 4'h1);
    tick();
    set_store(1'b0, '0, '0, '0);
    #1;
    checks++;
    if (count !== CW'(2) || dc_req_data !== 32'h01020304) begin
      failures++;
      $display("[TB] FAIL head_alloc got c=%0d d=%h want 2/01020304", count, dc_req_data);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    set_store(1'b1, 32'h400, 32'hAAAAAAAA, 4'hF);
    tick();
    set_store(1'b1, 32'h400, 32'h000000BB, 4'h1);
    tick();
    set_store(1'b1, 32'h600, 32'h12345678, 4'hF);
    ld_addr = 32'h402;
    #1;
    checks++;
    if (fwd_mask !== 4'hF || fwd_data !== 32'hAAAAAABB) begin
      failures++;
      $display("[TB] FAIL fwd_hit got fd=%h fm=%h want aaaaaabb/f", fwd_data, fwd_mask);
    end
    ld_addr = 32'h600;
    #1;
    checks++;
    if (fwd_mask !== 4'h0 || fwd_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL fwd_nobypass got fd=%h fm=%h want 0/0", fwd_data, fwd_mask);
    end
    set_store(1'b0, '0, '0, '0);
    ld_addr = 32'h500;
    #1;
    checks++;
    if (fwd_mask !== 4'h0 || fwd_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL fwd_miss got fd=%h fm=%h want 0/0", fwd_data, fwd_mask);
    end
    ld_addr = 32'h400;
    dc_req_accept = 1'b1;
    tick();
    dc_req_accept = 1'b1;
    #1;
    checks++;
    if (fwd_mask !== 4'h1 || fwd_data !== 32'h000000BB) begin
      failures++;
      $display("[TB] FAIL fwd_headaccept got fd=%h fm=%h want 000000bb/1", fwd_data, fwd_mask);
    end
    tick();
    dc_req_accept = 1'b0;
  endtask

  task automatic test_reset_mid();
    int issued;
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h900 + 32'(8*i), 32'(i), 4'hF);
      tick();
    end
    set_store(1'b0, '0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (count !== '0 || dc_req_valid !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset got c=%0d v=%0b e=%0b want 0/0/1", count, dc_req_valid, empty);
    end
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge clock);
    #1;
    checks++;
    if (dc_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_release got v=%0b want 0", dc_req_valid);
    end
    issued = 0;
    cyc = 0;
    while ((issued < 6 || q.size() != 0) && cyc < 200) begin
      if (issued < 6) set_store(1'b1, 32'h700 + 32'(4*issued), 32'hC0DE0000 + 32'(issued), 4'hF);
      else set_store(1'b0, '0, '0, '0);
      dc_req_accept = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (dc_req_valid !== (q.size() != 0) ||
          (q.size() != 0 && dc_req_addr !== {q[0].a, 2'b00})) begin
        failures++;
        $display("[TB] FAIL wrap_order got v=%0b a=%h want v=%0b a=%h", dc_req_valid, dc_req_addr,
                 (q.size() != 0), (q.size() != 0) ? {q[0].a, 2'b00} : 32'h0);
      end
      if (sq_accept) issued++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      failures++;
      $display("[TB] FAIL wrap_timeout got cycles=%0d want <200", cyc);
    end
    dc_req_accept = 1'b0;
  endtask

  task automatic test_random();
    logic [35:0] ef;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      set_store($urandom_range(0, 3) != 0,
                32'h800 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3)),
                $urandom, 4'($urandom));
      dc_req_accept = ($urandom_range(0, 2) == 0);
      ld_addr = 32'h800 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      #1;
      ef = m_fwd(ld_addr);
      checks++;
      if (sq_accept !== m_acc()) begin
        failures++;
        $display("[TB] FAIL rnd_accept cyc=%0d got %0b want %0b", n, sq_accept, m_acc());
      end
      checks++;
      if (count !== CW'(q.size()) || empty !== (q.size() == 0) || dc_req_valid !== (q.size() != 0)) begin
        failures++;
        $display("[TB] FAIL rnd_count cyc=%0d got c=%0d e=%0b v=%0b want c=%0d", n, count, empty, dc_req_valid, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (dc_req_addr !== {q[0].a, 2'b00} || dc_req_data !== q[0].d || dc_req_byte_mask !== q[0].m) begin
          failures++;
          $display("[TB] FAIL rnd_head cyc=%0d got a=%h d=%h m=%h want a=%h d=%h m=%h", n,
                   dc_req_addr, dc_req_data, dc_req_byte_mask, {q[0].a, 2'b00}, q[0].d, q[0].m);
        end
      end
      checks++;
      if ({fwd_mask, fwd_data} !== ef) begin
        failures++;
        $display("[TB] FAIL rnd_fwd cyc=%0d got fm=%h fd=%h want fm=%h fd=%h", n, fwd_mask, fwd_data, ef[35:32], ef[31:0]);
      end
      tick();
    end
    set_store(1'b0, '0, '0, '0);
    dc_req_accept = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full();
    test_coalesce();
    test_head_no_coalesce();
    test_forwarding();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
